// File: rtl/fetch_pkg.sv
// Shared types and default sizing for the instruction fetch responder.
package fetch_pkg;

  // Fetch controller states, fixed 3-bit encoding.
  typedef enum logic [2:0] {
    IDLE = 3'd0,
    REQ  = 3'd1,
    WAIT = 3'd2,
    HOLD = 3'd3,
    ERR  = 3'd4
  } fetch_state_t;

  localparam int FETCH_BITS     = 32;
  localparam int FETCH_WAIT_MAX = 16;

endpackage

// File: rtl/instr_fetch.sv
// Instruction fetch responder: requests the word at the PC address, captures
// the memory response, hands it to decode over valid/ready and pulses
// load_instr on acceptance. A wait timer raises a sticky fault when memory
// never answers.
module instr_fetch
  import fetch_pkg::*;
#(
  parameter int BITS     = FETCH_BITS,
  parameter int WAIT_MAX = FETCH_WAIT_MAX
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [BITS-1:0] pc_addr,
  output logic            load_instr,
  output logic            mem_req,
  output logic [BITS-1:0] mem_addr,
  input  logic            mem_gnt,
  input  logic            mem_rvalid,
  input  logic [BITS-1:0] mem_rdata,
  output logic [BITS-1:0] instr,
  output logic [BITS-1:0] instr_addr,
  output logic            instr_valid,
  input  logic            instr_ready,
  output logic            fetch_err
);

  // Counter wide enough to reach WAIT_MAX-1 without wrapping.
  localparam int                CNT_W     = $clog2(WAIT_MAX);
  localparam logic [CNT_W-1:0]  CNT_LIMIT = CNT_W'(WAIT_MAX - 1);
  localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);

  fetch_state_t     state_r;
  fetch_state_t     state_nxt_s;
  logic [BITS-1:0]  instr_r;
  logic [BITS-1:0]  instr_addr_r;
  logic [CNT_W-1:0] wait_cnt_r;
  logic             fetch_err_r;

  // Next-state decode; memory responses are only honoured in WAIT, so stray
  // rvalid pulses from before a reset are dropped in IDLE/REQ.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        state_nxt_s = REQ;
      end
      REQ: begin
        if (mem_gnt) begin
          state_nxt_s = WAIT;
        end else begin
          state_nxt_s = REQ;
        end
      end
      WAIT: begin
        if (mem_rvalid) begin
          state_nxt_s = HOLD;
        end else if (wait_cnt_r == CNT_LIMIT) begin
          state_nxt_s = ERR;
        end else begin
          state_nxt_s = WAIT;
        end
      end
      HOLD: begin
        if (instr_ready) begin
          state_nxt_s = REQ;
        end else begin
          state_nxt_s = HOLD;
        end
      end
      ERR: begin
        state_nxt_s = ERR;
      end
      default: begin
        state_nxt_s = IDLE;
      end
    endcase
  end

  // Handshake outputs; mem_addr follows the PC while requesting and the
  // latched address while the response is outstanding.
  always_comb begin
    mem_req     = 1'b0;
    mem_addr    = {BITS{1'b0}};
    instr_valid = 1'b0;
    load_instr  = 1'b0;
    case (state_r)
      REQ: begin
        mem_req  = 1'b1;
        mem_addr = pc_addr;
      end
      WAIT: begin
        mem_addr = instr_addr_r;
      end
      HOLD: begin
        instr_valid = 1'b1;
        mem_addr    = instr_addr_r;
        if (instr_ready) begin
          load_instr = 1'b1;
        end else begin
          load_instr = 1'b0;
        end
      end
      default: begin
        mem_req = 1'b0;
      end
    endcase
  end

  // State, capture registers, wait timer and sticky fault flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r      <= IDLE;
      instr_r      <= {BITS{1'b0}};
      instr_addr_r <= {BITS{1'b0}};
      wait_cnt_r   <= {CNT_W{1'b0}};
      fetch_err_r  <= 1'b0;
    end else begin
      state_r     <= state_nxt_s;
      fetch_err_r <= (state_nxt_s == ERR);
      case (state_r)
        REQ: begin
          if (mem_gnt) begin
            instr_addr_r <= pc_addr;
            wait_cnt_r   <= {CNT_W{1'b0}};
          end
        end
        WAIT: begin
          if (mem_rvalid) begin
            instr_r <= mem_rdata;
          end else if (wait_cnt_r != CNT_LIMIT) begin
            wait_cnt_r <= wait_cnt_r + CNT_ONE;
          end
        end
        default: begin
          wait_cnt_r <= wait_cnt_r;
        end
      endcase
    end
  end

  assign instr      = instr_r;
  assign instr_addr = instr_addr_r;
  assign fetch_err  = fetch_err_r;

endmodule

// File: tb/tb_instr_fetch.sv
// Directed and randomized bench for instr_fetch. The bench plays both PC and
// instruction memory; memory content is a fixed hash of the address.
module tb_instr_fetch;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] pc_addr;
  logic        load_instr;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_gnt;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;
  logic [31:0] instr;
  logic [31:0] instr_addr;
  logic        instr_valid;
  logic        instr_ready;
  logic        fetch_err;

  int checks = 0;
  int errors = 0;
  logic [31:0] pc;

  instr_fetch #(.BITS(32), .WAIT_MAX(16)) dut (
    .clk(clk), .rst(rst), .pc_addr(pc_addr), .load_instr(load_instr),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_gnt(mem_gnt),
    .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata), .instr(instr),
    .instr_addr(instr_addr), .instr_valid(instr_valid),
    .instr_ready(instr_ready), .fetch_err(fetch_err)
  );

  always #5 clk = ~clk;

  // Memory content model.
  function automatic logic [31:0] memword(input logic [31:0] a);
    return (a * 32'h9E3779B1) ^ 32'h5A5A5A5A;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Apply inputs at the falling edge, then let combinational outputs settle.
  task automatic drive(input logic r, input logic g, input logic v,
                       input logic [31:0] d, input logic rdy);
    @(negedge clk);
    rst = r; mem_gnt = g; mem_rvalid = v; mem_rdata = d; instr_ready = rdy;
    #1;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_req"},   {31'd0, mem_req},     32'd0);
    chk({tag, "_maddr"}, mem_addr,             32'd0);
    chk({tag, "_load"},  {31'd0, load_instr},  32'd0);
    chk({tag, "_instr"}, instr,                32'd0);
    chk({tag, "_iaddr"}, instr_addr,           32'd0);
    chk({tag, "_valid"}, {31'd0, instr_valid}, 32'd0);
    chk({tag, "_err"},   {31'd0, fetch_err},   32'd0);
  endtask

  // One complete fetch of addr with chosen grant delay, memory latency and
  // decode backpressure; every cycle is checked against the expected protocol.
  task automatic fetch_one(input logic [31:0] addr, input int gnt_stall,
                           input int wait_lat, input int hold_stall);
    logic [31:0] data;
    data = memword(addr);
    pc_addr = addr;
    for (int i = 0; i < gnt_stall; i++) begin
      drive(1'b0, 1'b0, 1'($urandom_range(0, 1)), $urandom, 1'($urandom_range(0, 1)));
      chk("stall_req",   {31'd0, mem_req},     32'd1);
      chk("stall_maddr", mem_addr,             addr);
      chk("stall_valid", {31'd0, instr_valid}, 32'd0);
      chk("stall_err",   {31'd0, fetch_err},   32'd0);
    end
    drive(1'b0, 1'b1, 1'($urandom_range(0, 1)), $urandom, 1'($urandom_range(0, 1)));
    chk("req_req",   {31'd0, mem_req},    32'd1);
    chk("req_maddr", mem_addr,            addr);
    chk("req_load",  {31'd0, load_instr}, 32'd0);
    for (int i = 0; i < wait_lat; i++) begin
      drive(1'b0, 1'($urandom_range(0, 1)), 1'b0, $urandom, 1'($urandom_range(0, 1)));
      chk("wait_req",   {31'd0, mem_req},     32'd0);
      chk("wait_valid", {31'd0, instr_valid}, 32'd0);
      chk("wait_err",   {31'd0, fetch_err},   32'd0);
    end
    drive(1'b0, 1'b0, 1'b1, data, 1'($urandom_range(0, 1)));
    chk("rsp_req",   {31'd0, mem_req},     32'd0);
    chk("rsp_valid", {31'd0, instr_valid}, 32'd0);
    chk("rsp_err",   {31'd0, fetch_err},   32'd0);
    for (int i = 0; i < hold_stall; i++) begin
      drive(1'b0, 1'($urandom_range(0, 1)), 1'b0, $urandom, 1'b0);
      chk("bp_valid", {31'd0, instr_valid}, 32'd1);
      chk("bp_instr", instr,                data);
      chk("bp_iaddr", instr_addr,           addr);
      chk("bp_load",  {31'd0, load_instr},  32'd0);
      chk("bp_req",   {31'd0, mem_req},     32'd0);
    end
    drive(1'b0, 1'b0, 1'b0, $urandom, 1'b1);
    chk("acc_valid", {31'd0, instr_valid}, 32'd1);
    chk("acc_instr", instr,                data);
    chk("acc_iaddr", instr_addr,           addr);
    chk("acc_load",  {31'd0, load_instr},  32'd1);
  endtask

  initial begin
    rst = 1'b1; pc_addr = 32'd0; mem_gnt = 1'b0; mem_rvalid = 1'b0;
    mem_rdata = 32'd0; instr_ready = 1'b0;

    // Reset state.
    drive(1'b1, 1'b1, 1'b1, 32'hFFFF_FFFF, 1'b1);
    chk_zero("rst");
    drive(1'b0, 1'b0, 1'b0, 32'd0, 1'b1);
    chk("idle_req", {31'd0, mem_req}, 32'd0);

    // First fetch after reset: REQ in cycle 1, word presented in cycle 3.
    drive(1'b0, 1'b1, 1'b0, 32'd0, 1'b1);
    chk("t1_req",   {31'd0, mem_req}, 32'd1);
    chk("t1_maddr", mem_addr,         32'd0);
    drive(1'b0, 1'b0, 1'b1, 32'h8C22_0004, 1'b1);
    chk("t1_wait", {31'd0, instr_valid}, 32'd0);
    drive(1'b0, 1'b0, 1'b0, 32'd0, 1'b1);
    chk("t1_valid", {31'd0, instr_valid}, 32'd1);
    chk("t1_instr", instr,                32'h8C22_0004);
    chk("t1_iaddr", instr_addr,           32'd0);
    chk("t1_load",  {31'd0, load_instr},  32'd1);

    // Back-to-back sequential fetches, 3 cycles each.
    for (int a = 1; a <= 3; a++) fetch_one(32'(a), 0, 0, 0);

    // Decode backpressure for 5 cycles, then a jump target.
    fetch_one(32'd4, 0, 0, 5);
    fetch_one(32'h0000_1000, 0, 0, 0);

    // Grant withheld for 10 cycles.
    fetch_one(32'h0000_1001, 10, 0, 0);

    // Response exactly in the limit cycle wins over the timeout.
    fetch_one(32'h0000_1002, 0, 15, 0);

    // Randomized traffic with a sequential/jump PC model.
    pc = 32'h0000_2000;
    for (int n = 0; n < 60; n++) begin
      fetch_one(pc, $urandom_range(0, 3),
                ($urandom_range(0, 7) == 0) ? 15 : $urandom_range(0, 4),
                $urandom_range(0, 3));
      pc = ($urandom_range(0, 3) == 0) ? $urandom : pc + 32'd1;
    end

    // Timeout: grant, then no response for 16 cycles.
    pc_addr = 32'h0000_3000;
    drive(1'b0, 1'b1, 1'b0, 32'd0, 1'b0);
    chk("to_req", {31'd0, mem_req}, 32'd1);
    for (int i = 0; i < 16; i++) begin
      drive(1'b0, 1'b0, 1'b0, 32'd0, 1'b0);
      chk("to_noerr", {31'd0, fetch_err}, 32'd0);
    end
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 1'b1, 1'b1, 32'h1234_5678, 1'b1);
      chk("to_err",   {31'd0, fetch_err},   32'd1);
      chk("to_req0",  {31'd0, mem_req},     32'd0);
      chk("to_valid", {31'd0, instr_valid}, 32'd0);
      chk("to_load",  {31'd0, load_instr},  32'd0);
    end
    drive(1'b1, 1'b0, 1'b0, 32'd0, 1'b0);
    chk_zero("to_rst");
    drive(1'b0, 1'b0, 1'b0, 32'd0, 1'b0);
    chk("to_idle", {31'd0, fetch_err}, 32'd0);
    fetch_one(32'h0000_3004, 0, 1, 0);

    // Reset while waiting; late response after release must be dropped.
    pc_addr = 32'h0000_4000;
    drive(1'b0, 1'b1, 1'b0, 32'd0, 1'b0);
    drive(1'b0, 1'b0, 1'b0, 32'd0, 1'b0);
    drive(1'b1, 1'b0, 1'b0, 32'd0, 1'b0);
    chk_zero("rw_rst");
    pc_addr = 32'h0000_4040;
    drive(1'b0, 1'b0, 1'b1, 32'hDEAD_BEEF, 1'b1);
    chk("rw_idle_valid", {31'd0, instr_valid}, 32'd0);
    drive(1'b0, 1'b0, 1'b1, 32'hDEAD_BEEF, 1'b1);
    chk("rw_req",   {31'd0, mem_req},     32'd1);
    chk("rw_maddr", mem_addr,             32'h0000_4040);
    chk("rw_valid", {31'd0, instr_valid}, 32'd0);
    chk("rw_instr", instr,                32'd0);
    fetch_one(32'h0000_4040, 0, 1, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/instr_fetch.md
Name: instr_fetch

Overview:
Instruction fetch responder that sits between the program counter and instruction memory.
- Consumes the PC's current address, issues a read request to instruction memory and captures the returned word.
- Presents the word to decode with a valid/ready handshake.
- Returns the single-cycle load_instr enable that advances the PC.
- A wait timer detects a memory that never responds and raises a sticky fetch fault.

Parameters:
BITS, 32, word and address width (matches PC width)
WAIT_MAX, 16, maximum cycles in WAIT before timeout fault; legal range 2..255

Ports:
clk  input  1  system clock
rst  input  1  asynchronous, active-high reset
pc_addr  input  BITS  current instruction address from the PC
load_instr  output  1  PC load enable; high exactly in the cycle decode accepts an instruction
mem_req  output  1  instruction memory read request
mem_addr  output  BITS  instruction memory read address
mem_gnt  input  1  memory accepted request (sampled only while mem_req=1)
mem_rvalid  input  1  read data valid; at least 1 cycle after the gnt cycle
mem_rdata  input  BITS  read data
instr  output  BITS  fetched instruction word to decode
instr_addr  output  BITS  address the presented instr was fetched from
instr_valid  output  1  instr/instr_addr valid
instr_ready  input  1  decode accepts instr this cycle
fetch_err  output  1  sticky timeout fault

Behaviour:
- Reset: one clock; rst is asynchronous and active-high.
  - On rst: state=IDLE, instr=0, instr_addr=0, wait_cnt=0, fetch_err=0.
  - All outputs are low/zero while rst is high.
- States: IDLE, REQ, WAIT, HOLD, ERR.
- IDLE: all outputs low. Always moves to REQ next cycle, so the first fetch follows reset by one cycle.
- REQ:
  - mem_req=1, mem_addr=pc_addr (combinational).
  - pc_addr is stable here because load_instr is low.
  - mem_gnt=1: latch pc_addr into instr_addr, clear wait_cnt, go to WAIT.
  - mem_gnt=0: stay in REQ indefinitely; no timeout applies in REQ.
  - mem_rvalid is ignored in REQ. This drops stray responses left over from before a reset.
- WAIT:
  - mem_req=0, mem_addr=instr_addr.
  - mem_rvalid=1: capture mem_rdata into instr, go to HOLD.
  - Otherwise wait_cnt increments. When wait_cnt==WAIT_MAX-1 and mem_rvalid=0, go to ERR.
  - If mem_rvalid arrives in the same cycle as the limit, the data wins and the state goes to HOLD.
- HOLD:
  - instr_valid=1; instr and instr_addr are held constant.
  - instr_ready=1: load_instr=1 in that same cycle (combinational: HOLD && instr_ready), go to REQ.
  - The PC updates on that edge, so the next REQ uses the new pc_addr (sequential, jump or branch target).
  - instr_ready=0: stay in HOLD and hold all values.
- ERR:
  - fetch_err=1; mem_req, instr_valid and load_instr are 0.
  - Stays in ERR until rst.
- Throughput: with gnt in the REQ cycle and rvalid in the next cycle, an instruction is presented 2 cycles after REQ entry. Best case is 3 cycles per instruction.
- Counter width: $clog2(WAIT_MAX) bits. The counter must not wrap before the fault triggers.
- load_instr is never high outside HOLD. The PC therefore never advances without an accepted instruction.
- Reset mid-operation (REQ, WAIT or HOLD): returns to IDLE and discards the captured word. A late mem_rvalid after reset is ignored.
- One outstanding memory request at most. No new request is issued until the current instruction is accepted.

Decomposition:
- Package fetch_pkg holds:
  - enum fetch_state_t {IDLE, REQ, WAIT, HOLD, ERR}, 3-bit encoding;
  - default constants FETCH_BITS=32 and FETCH_WAIT_MAX=16.
- No sub-module is needed. The FSM, capture registers and wait counter are all implemented in instr_fetch.

Test Plan:
1. Reset release with pc_addr=0x00000000; memory grants immediately and returns 0x8C220004 one cycle later; instr_ready=1 -> mem_req high in cycle 1 after reset, instr_valid with instr=0x8C220004 and instr_addr=0 in cycle 3, load_instr pulses once in cycle 3.
2. Back-to-back: PC model increments by 1; memory answers 1 cycle after gnt -> instr_addr sequence 0,1,2,3, exactly one load_instr per accepted instruction, 3-cycle spacing.
3. Backpressure: instr_ready held 0 for 5 cycles in HOLD -> instr/instr_addr stable, load_instr=0, mem_req=0 throughout. On ready, a single load_instr pulse, then REQ with the new pc_addr.
4. Grant stall: mem_gnt low for 10 cycles in REQ -> mem_req and mem_addr held, no fetch_err. Fetch then completes normally.
5. Timeout: gnt given, rvalid never asserted, WAIT_MAX=16 -> fetch_err rises 16 cycles after the gnt edge and remains set, mem_req=0. rst clears fetch_err. Separately, rvalid in exactly the limit cycle -> HOLD, no fault.
6. Reset in WAIT: assert rst, then drive mem_rvalid=1 with 0xDEADBEEF after release -> word ignored, instr_valid stays 0, a fresh REQ is issued for the current pc_addr.
